// File: rtl/uart_receiver_param.sv
// UART receive engine: oversampled frame recovery into a valid/ready holding register.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over three consecutive ticks per bit.
module uart_receiver_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int unsigned Mid  = OVERSAMPLE / 2;
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] StartLast = CntW'(Mid - 1);
  localparam logic [CntW-1:0] BitLast   = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] DataLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic                   par_bit_q, par_bit_d, stop1_low_q, stop1_low_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                   brk_q, brk_d, ovr_q, ovr_d;
  logic                   sync1_q, sync2_q, rx_s, bit_s, sample_hit;
  logic                   done, fin_ferr, fin_all_low, fin_perr, fin_brk, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // Line history at the two previous ticks; the vote includes the current tick.
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d = hist_q;
    if (baud_tick) hist_d = {hist_q[0], rx_s};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end
  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  assign sample_hit = baud_tick && (cnt_q == ((state_q == StStart) ? StartLast : BitLast));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    stop1_low_d = stop1_low_q;
    done        = 1'b0;
    fin_ferr    = 1'b0;
    fin_all_low = 1'b0;
    if (state_q != StIdle && state_q != StBrkWait && baud_tick) begin
      cnt_d = sample_hit ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (sample_hit) begin
          if (!bit_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
            par_en_d  = cfg_parity_en;
            par_odd_d = cfg_parity_odd;
            stop2_d   = cfg_stop2;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample_hit) begin
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DataLast) state_d = par_en_q ? StParity : StStop1;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (sample_hit) begin
          par_bit_d = bit_s;
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (sample_hit) begin
          if (stop2_q) begin
            stop1_low_d = !bit_s;
            state_d     = StStop2;
          end else begin
            done        = 1'b1;
            fin_ferr    = !bit_s;
            fin_all_low = !bit_s;
          end
        end
      end
      StStop2: begin
        if (sample_hit) begin
          done        = 1'b1;
          fin_ferr    = stop1_low_q | !bit_s;
          fin_all_low = stop1_low_q & !bit_s;
        end
      end
      StBrkWait: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    fin_perr = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
    fin_brk  = (shift_q == '0) & !(par_en_q & par_bit_q) & fin_all_low;
    // Leave mid-stop so a following start edge is caught without delay.
    if (done) state_d = fin_brk ? StBrkWait : StIdle;
  end

  always_comb begin
    accept  = valid_q & rx_ready;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = fin_ferr;
        perr_d  = fin_perr;
        brk_d   = fin_brk;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      par_bit_q   <= 1'b0;
      stop1_low_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      brk_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      par_bit_q   <= par_bit_d;
      stop1_low_q <= stop1_low_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      brk_q       <= brk_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign rx_break      = brk_q;
  assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_receiver_param.sv
// Directed bench for uart_receiver_param (8 data bits, 16x oversampling, tick every 4 clocks).
// Received words are logged as {break, parity_err, frame_err, data}.
module tb_uart_receiver_param;

  logic       clk, rst_n, baud_tick, rx_serial;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_frame_err, rx_parity_err, rx_break, rx_overrun;
  logic [1:0] tick_div;
  logic [10:0] got_q[$];
  int         n_pass = 0;
  int         n_total = 0;

  uart_receiver_param #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .rx_serial     (rx_serial),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_break      (rx_break),
    .rx_overrun    (rx_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    tick_div  = 2'd0;
    forever begin
      @(negedge clk);
      tick_div  = tick_div + 2'd1;
      baud_tick = (tick_div == 2'd0);
    end
  end

  // rx_ready only changes just after a rising edge, so this predicts the next transfer.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready)
      got_q.push_back({rx_break, rx_parity_err, rx_frame_err, rx_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    if (got_q.size() == 0) obs = 32'hDEAD_BEEF;
    else                   obs = {21'b0, got_q.pop_front()};
    check(tag, obs, exp);
  endtask

  task automatic wait_tick();
    @(posedge clk iff baud_tick === 1'b1);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    repeat (n) begin
      rx_serial = b;
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input int nstop);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    if (pen) send_bit(pbit, 16);
    send_bit(1'b1, 16 * nstop);
    send_bit(1'b1, 32);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  initial begin
    logic [7:0] d;
    rst_n          = 1'b0;
    rx_serial      = 1'b1;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b0;
    rx_ready       = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid",   {31'b0, rx_valid},      32'h0);
    check("rst_data",    {24'b0, rx_data},       32'h0);
    check("rst_ferr",    {31'b0, rx_frame_err},  32'h0);
    check("rst_perr",    {31'b0, rx_parity_err}, 32'h0);
    check("rst_break",   {31'b0, rx_break},      32'h0);
    check("rst_overrun", {31'b0, rx_overrun},    32'h0);
    rst_n = 1'b1;
    send_bit(1'b1, 32);

    // 8N1 back-to-back words
    send_frame(8'h41, 1'b0, 1'b0, 1);
    send_frame(8'h42, 1'b0, 1'b0, 1);
    check("8n1_count", 32'(got_q.size()), 32'd2);
    pop_check("8n1_w0", 32'h041);
    pop_check("8n1_w1", 32'h042);

    // 0xA5 has even popcount: parity bit 1 is wrong for even, right for odd
    cfg_parity_en = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    pop_check("8e1_bad_parity", 32'h2A5);
    cfg_parity_odd = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    pop_check("8o1_good_parity", 32'h0A5);

    // 8N2 with second stop bit low up to its sample point
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b1;
    d = 8'h3C;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 8);
    send_bit(1'b1, 48);
    check("stop2_count", 32'(got_q.size()), 32'd1);
    pop_check("stop2_ferr", 32'h13C);

    // Break: line low for 12 bit times
    send_bit(1'b0, 192);
    check("break_count_low", 32'(got_q.size()), 32'd1);
    send_bit(1'b1, 48);
    check("break_count_high", 32'(got_q.size()), 32'd1);
    pop_check("break_word", 32'h500);

    // Overrun while the holding register is full
    cfg_stop2 = 1'b0;
    set_ready(1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1);
    check("ovr_first_flag", {31'b0, rx_overrun}, 32'h0);
    send_frame(8'h22, 1'b0, 1'b0, 1);
    check("ovr_valid", {31'b0, rx_valid},   32'h1);
    check("ovr_data",  {24'b0, rx_data},    32'h11);
    check("ovr_flag",  {31'b0, rx_overrun}, 32'h1);
    check("ovr_none_taken", 32'(got_q.size()), 32'd0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("ovr_valid_clr", {31'b0, rx_valid},   32'h0);
    check("ovr_flag_clr",  {31'b0, rx_overrun}, 32'h0);
    pop_check("ovr_accepted", 32'h011);
    check("ovr_no_extra", 32'(got_q.size()), 32'd0);

    // Short start glitch
    send_bit(1'b0, 4);
    send_bit(1'b1, 48);
    check("glitch_start_count", 32'(got_q.size()), 32'd0);
    check("glitch_start_valid", {31'b0, rx_valid}, 32'h0);

    // Reset during data bits of 0x55, then a clean 0x66
    d = 8'h55;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(d[i], 16);
    rx_serial = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_valid", {31'b0, rx_valid}, 32'h0);
    rst_n = 1'b1;
    send_bit(1'b1, 32);
    send_frame(8'h66, 1'b0, 1'b0, 1);
    pop_check("midrst_word", 32'h066);
    check("midrst_count", 32'(got_q.size()), 32'd0);

    // One inverted tick at the sample point of bit 3 of 0xF0
    d = 8'hF0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        send_bit(1'b0, 7);
        send_bit(1'b1, 1);
        send_bit(1'b0, 8);
      end else begin
        send_bit(d[i], 16);
      end
    end
    send_bit(1'b1, 48);
`ifdef UART_RX_MAJORITY_EN
    pop_check("bit_glitch", 32'h0F0);
`else
    pop_check("bit_glitch", 32'h0F8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
